turf_udp_rdwr_exec: RTL

Executes the buffered UDP read/write control stream produced by the header/payload combiner and its FIFO. Each packet arrives as one header word, then payload words; each payload word is one 32-bit register transaction on the simple en/wr/ack memory bus. For every executed packet it emits a response header and one response payload word per input payload word, toward the UDP transmit path.

---
 rtl/turf_udp_rdwr_exec.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/turf_udp_rdwr_exec.sv
// Executes buffered UDP read/write packets as 32-bit register accesses on the en/wr/ack bus.
// Emits one response header per packet and one response payload word per input payload word.
module turf_udp_rdwr_exec #(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hFFFFFFFF
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [63:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [3:0]  s_axis_tuser,
    input  logic        s_axis_tlast,
    output logic [63:0] m_hdr_tdata,
    output logic        m_hdr_tvalid,
    input  logic        m_hdr_tready,
    output logic        m_hdr_tuser,
    output logic [63:0] m_payload_tdata,
    output logic        m_payload_tvalid,
    input  logic        m_payload_tready,
    output logic [7:0]  m_payload_tkeep,
    output logic        m_payload_tlast,
    output logic        en_o,
    output logic        wr_o,
    input  logic        ack_i,
    output logic [27:0] adr_o,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    // Handshake: a word moves on any channel only in a cycle where valid and ready are both high;
    // a producer holds valid and data unchanged until that cycle.
    typedef enum logic [2:0] {IDLE, HDR, FETCH, ACCESS, RESP, DRAIN} state_t;

    state_t        state;
    logic          read_flag;
    logic [31:0]   addr_word;
    logic [31:0]   resp_data;
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept          = s_axis_tvalid && s_axis_tready;
    assign m_hdr_tuser     = read_flag;
    assign m_payload_tdata = {addr_word, resp_data};
    assign m_payload_tkeep = 8'hFF;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state            <= IDLE;
            s_axis_tready    <= 1'b0;
            m_hdr_tdata      <= '0;
            m_hdr_tvalid     <= 1'b0;
            read_flag        <= 1'b0;
            m_payload_tvalid <= 1'b0;
            m_payload_tlast  <= 1'b0;
            addr_word        <= '0;
            resp_data        <= '0;
            en_o             <= 1'b0;
            wr_o             <= 1'b0;
            adr_o            <= '0;
            dat_o            <= '0;
            cnt              <= '0;
        end else begin
            case (state)
                IDLE: begin
                    s_axis_tready <= 1'b1;
                    if (accept && !s_axis_tlast) begin
                        if (s_axis_tuser[1]) begin
                            m_hdr_tdata   <= s_axis_tdata;
                            read_flag     <= s_axis_tuser[0];
                            m_hdr_tvalid  <= 1'b1;
                            s_axis_tready <= 1'b0;
                            state         <= HDR;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (accept && s_axis_tlast) begin
                        state <= IDLE;
                    end
                end
                HDR: begin
                    if (m_hdr_tready) begin
                        m_hdr_tvalid  <= 1'b0;
                        s_axis_tready <= 1'b1;
                        state         <= FETCH;
                    end
                end
                FETCH: begin
                    if (accept) begin
                        addr_word       <= s_axis_tdata[63:32];
                        m_payload_tlast <= s_axis_tlast;
                        s_axis_tready   <= 1'b0;
                        // Only a full 64-bit payload word (both halves valid) becomes a bus access.
                        if (s_axis_tuser[3:2] == 2'b11 && !s_axis_tuser[1]) begin
                            en_o  <= 1'b1;
                            wr_o  <= !read_flag;
                            adr_o <= s_axis_tdata[59:32];
                            dat_o <= s_axis_tdata[31:0];
                            cnt   <= '0;
                            state <= ACCESS;
                        end else begin
                            resp_data        <= '0;
                            m_payload_tvalid <= 1'b1;
                            state            <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    if (en_o && ack_i) begin
                        resp_data        <= wr_o ? dat_o : dat_i;
                        en_o             <= 1'b0;
                        m_payload_tvalid <= 1'b1;
                        state            <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        resp_data        <= wr_o ? dat_o : ERR_DATA;
                        en_o             <= 1'b0;
                        m_payload_tvalid <= 1'b1;
                        state            <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (m_payload_tready) begin
                        m_payload_tvalid <= 1'b0;
                        s_axis_tready    <= 1'b1;
                        state            <= m_payload_tlast ? IDLE : FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
